// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared encodings for the RV32I multi-cycle sequencer: the FSM state
// encoding, the RV32I major opcode constants and the opcode-class struct
// produced by the opcode classifier. Stage logic and monitors import this
// package so everyone agrees on the same numbers.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

   // Sequencer states; the numeric values are visible on the state output.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   // RV32I major opcodes (instr[6:0]).
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // One-hot opcode class. is_trap covers SYSTEM and every unknown opcode.
   typedef struct packed {
      logic is_load;
      logic is_store;
      logic is_alu;
      logic is_branch;
      logic is_fence;
      logic is_trap;
   } opc_class_t;

   // Opcodes that compute a result and go straight to write-back.
   function automatic logic is_alu_opcode(input logic [6:0] opc);
      return (opc == OPC_OP)    || (opc == OPC_OP_IMM) ||
             (opc == OPC_LUI)   || (opc == OPC_AUIPC)  ||
             (opc == OPC_JAL)   || (opc == OPC_JALR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle of every signal between the sequencer and the rest of the core.
//   master : the sequencer (drives state, enables, requests, counters)
//   slave  : datapath / memory side (drives run, opcode, regwrite, readies)
// Handshake: imem_req/imem_ready and dmem_req/dmem_ready are valid/ready
// pairs. A ready is only meaningful while its req is high; once req goes
// high it stays high until the cycle in which ready is seen, and the
// transfer completes in that same cycle.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic [6:0]       opcode;
   logic             id_regwrite;
   logic             imem_ready;
   logic             dmem_ready;
   logic [2:0]       state;
   logic             imem_req;
   logic             ir_we;
   logic             dmem_req;
   logic             dmem_we;
   logic             rf_we;
   logic             pc_we;
   logic             halted;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   modport master (
      input  run, opcode, id_regwrite, imem_ready, dmem_ready,
      output state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
             halted, cycle_cnt, instret_cnt
   );

   modport slave (
      output run, opcode, id_regwrite, imem_ready, dmem_ready,
      input  state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
             halted, cycle_cnt, instret_cnt
   );
endinterface

// File: rtl/multicycle_ctrl_opcode_class.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_opcode_class
// Purely combinational classifier: maps the 7-bit RV32I opcode to a one-hot
// class used by the sequencer to pick its state path.
//   i_opcode : instr[6:0] of the latched IR
//   o_class  : one-hot {is_load, is_store, is_alu, is_branch, is_fence, is_trap}
// -----------------------------------------------------------------------------
module multicycle_ctrl_opcode_class
   import multicycle_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output opc_class_t o_class
);

   always_comb begin
      o_class = '0;
      if (i_opcode == OPC_LOAD) begin
         o_class.is_load = 1'b1;
      end else if (i_opcode == OPC_STORE) begin
         o_class.is_store = 1'b1;
      end else if (is_alu_opcode(i_opcode)) begin
         o_class.is_alu = 1'b1;
      end else if (i_opcode == OPC_BRANCH) begin
         o_class.is_branch = 1'b1;
      end else if (i_opcode == OPC_FENCE) begin
         o_class.is_fence = 1'b1;
      end else begin
         // SYSTEM and anything unrecognised both stop the core.
         o_class.is_trap = 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main sequencer of the RV32I multi-cycle core. Walks each instruction
// through FETCH, DECODE, EXEC, MEM and WB, issues the instruction/data memory
// requests, and drives the IR, PC and register-file write enables. Stops in
// TRAP on SYSTEM or illegal opcodes until reset. Also keeps a cycle counter
// (frozen in TRAP) and a retired-instruction counter (one per PC write).
// Ports:
//   clk : core clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : multicycle_ctrl_if master modport (inputs run, opcode,
//         id_regwrite, imem_ready, dmem_ready; outputs state, imem_req,
//         ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, cycle_cnt,
//         instret_cnt)
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_ctrl_if.master    bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic             r_imem_pend;     // fetch request issued, ready not yet seen
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instret_cnt;

   opc_class_t       w_cls;
   logic             w_imem_req;
   logic             w_ir_we;
   logic             w_dmem_req;
   logic             w_dmem_we;
   logic             w_rf_we;
   logic             w_pc_we;
   logic             w_halted;

   multicycle_ctrl_opcode_class u_opcode_class (
      .i_opcode (bus.opcode),
      .o_class  (w_cls)
   );

   // Enables are decoded straight from state, opcode class and the readies
   // so that a transfer completes in the cycle its ready arrives. rst masks
   // them so an access in flight is dropped immediately, not at the next edge.
   always_comb begin
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_rf_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_halted   = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_FETCH: begin
               // A pending request is held even if run drops meanwhile.
               w_imem_req = bus.run | r_imem_pend;
               w_ir_we    = w_imem_req & bus.imem_ready;
            end
            ST_EXEC: begin
               w_pc_we = w_cls.is_branch | w_cls.is_fence;
            end
            ST_MEM: begin
               w_dmem_req = 1'b1;
               w_dmem_we  = w_cls.is_store;
               w_pc_we    = w_cls.is_store & bus.dmem_ready;
            end
            ST_WB: begin
               w_rf_we = bus.id_regwrite;
               w_pc_we = 1'b1;
            end
            ST_TRAP: begin
               w_halted = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_FETCH;
         r_imem_pend   <= 1'b0;
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         r_imem_pend <= 1'b0;
         case (r_state)
            ST_FETCH: begin
               if (w_ir_we) begin
                  r_state <= ST_DECODE;
               end else begin
                  r_imem_pend <= w_imem_req;
               end
            end
            ST_DECODE: begin
               r_state <= w_cls.is_trap ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
               if (w_cls.is_load || w_cls.is_store) begin
                  r_state <= ST_MEM;
               end else if (w_cls.is_alu) begin
                  r_state <= ST_WB;
               end else if (w_cls.is_trap) begin
                  // Opcode changed under us since DECODE; stop rather than guess.
                  r_state <= ST_TRAP;
               end else begin
                  r_state <= ST_FETCH;
               end
            end
            ST_MEM: begin
               if (bus.dmem_ready) begin
                  r_state <= w_cls.is_store ? ST_FETCH : ST_WB;
               end
            end
            ST_WB: begin
               r_state <= ST_FETCH;
            end
            ST_TRAP: begin
               r_state <= ST_TRAP;
            end
            default: begin
               r_state <= ST_TRAP;
            end
         endcase

         if (r_state != ST_TRAP) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
         end
         if (w_pc_we) begin
            r_instret_cnt <= r_instret_cnt + CNT_ONE;
         end
      end
   end

   assign bus.state       = r_state;
   assign bus.imem_req    = w_imem_req;
   assign bus.ir_we       = w_ir_we;
   assign bus.dmem_req    = w_dmem_req;
   assign bus.dmem_we     = w_dmem_we;
   assign bus.rf_we       = w_rf_we;
   assign bus.pc_we       = w_pc_we;
   assign bus.halted      = w_halted;
   assign bus.cycle_cnt   = r_cycle_cnt;
   assign bus.instret_cnt = r_instret_cnt;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main sequencer for the RV32I multi-cycle core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables around the decode stage:
- IR latch
- PC write
- register-file write (wb_regwrite)
- instruction and data memory request handshakes

Classifies the opcode of the latched instruction and chooses the state path from it. Also keeps cycle and retired-instruction counters, and stops in a trap state on an illegal or system opcode.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt (wraps modulo 2^CNT_W)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  allows a new fetch to start; sampled only in FETCH
opcode  input  7  instr[6:0] of the latched IR
id_regwrite  input  1  decoded regwrite from the control unit
imem_ready  input  1  instruction memory data valid; qualified by imem_req
dmem_ready  input  1  data memory access complete; qualified by dmem_req
state  output  3  current state encoding
imem_req  output  1  instruction fetch request
ir_we  output  1  latch IR and old PC
dmem_req  output  1  data access request
dmem_we  output  1  data write (store)
rf_we  output  1  register-file write enable, feeds wb_regwrite
pc_we  output  1  PC update; one pulse per retired instruction
halted  output  1  core stopped in TRAP
cycle_cnt  output  CNT_W  cycles since reset, excluding TRAP
instret_cnt  output  CNT_W  retired instructions

Behaviour:
- Reset (asynchronous, active-high): state=FETCH and all outputs 0, including both counters. Reset asserted mid-access drops imem_req/dmem_req at once; no write enable may pulse.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Opcode classes:
  - LOAD 0000011
  - STORE 0100011
  - ALU: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011
  - FENCE 0001111 (executes as NOP)
  - SYSTEM 1110011
  - anything else is ILLEGAL
- FETCH:
  - imem_req = run.
  - On imem_req & imem_ready: ir_we=1 for one cycle, next state DECODE.
  - Otherwise stay in FETCH. With run=0 no request is issued.
- DECODE (one cycle; register file read):
  - SYSTEM or ILLEGAL -> TRAP.
  - Any other class -> EXEC.
- EXEC (one cycle):
  - LOAD or STORE -> MEM.
  - ALU -> WB.
  - BRANCH or FENCE: pc_we=1 (PC mux selects target or PC+4 outside this block), next state FETCH.
- MEM:
  - dmem_req held at 1 for the whole state.
  - dmem_we=1 while in MEM with a STORE opcode.
  - Leave MEM only on dmem_ready=1 in the same cycle. LOAD -> WB. STORE -> FETCH, with pc_we=1 in that cycle.
- WB (one cycle): rf_we=id_regwrite, pc_we=1, next state FETCH.
- TRAP: halted=1 and all enables 0. Stays in TRAP until rst.
- All outputs are Moore/combinational from state, opcode and ready; no extra latency.
- Handshake rules:
  - A ready input is ignored while its req is low.
  - Once asserted, a req is not withdrawn until ready is seen.
- Counters:
  - cycle_cnt +1 every cycle the state is not TRAP.
  - instret_cnt +1 on each pc_we.
  - Both wrap from all-ones to 0.
- Invariants:
  - At most one of ir_we, pc_we per cycle, except that rf_we and pc_we are both 1 in WB.
  - rf_we is only ever 1 in WB.
  - dmem_we implies dmem_req.
- Cycle count per instruction, with ready=1 immediately:
  - ALU: 4
  - BRANCH/FENCE: 3
  - STORE: 4
  - LOAD: 5

Decomposition:
- Shared defines file holds the state encodings and the RV32I opcode constants, so stage logic and testbench monitors use the same encodings.
- One combinational sub-module, opcode_class. It maps the 7-bit opcode to one-hot is_load, is_store, is_alu, is_branch, is_fence, is_trap.
- The FSM and counters stay in multicycle_ctrl.

Test Plan:
- ADD opcode 0110011, imem_ready=1 and id_regwrite=1 -> states 0,1,2,4. ir_we in cycle 1, rf_we and pc_we in cycle 4. instret_cnt=1, cycle_cnt=4.
- LW 0000011, dmem_ready held 0 for 3 MEM cycles then 1 -> dmem_req high for 4 cycles with dmem_we=0. WB follows; total 8 cycles.
- SW 0100011, dmem_ready=1 -> dmem_req and dmem_we for 1 cycle, pc_we in the same cycle, rf_we never asserted. Back in FETCH after 4 cycles.
- BEQ 1100011 then FENCE 0001111 -> each retires in 3 cycles with pc_we in EXEC. instret_cnt=2 after 6 cycles.
- Opcode 0000000 and, on a separate run, ECALL 1110011 -> TRAP after DECODE. halted=1 and cycle_cnt frozen for 20 cycles; rst returns to FETCH with counters at 0.
- rst pulsed while in MEM with dmem_req=1 -> dmem_req falls before the next edge with no dmem_we or pc_we pulse. With run=0 after reset: imem_req=0, state stays FETCH, cycle_cnt keeps counting.
